// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared bfloat16 types and adder latency
// Purpose: types and constants shared by the adder, the arbiter and the bench.
//   bf16_t     : 1-8-7 bfloat16 word
//   fp_flags_t : {underflow, overflow, inexact}
//   FP_ADD_LAT : pipeline depth of fp_add
package fp_pkg;
  typedef logic [15:0] bf16_t;

  typedef struct packed {
    logic underflow;
    logic overflow;
    logic inexact;
  } fp_flags_t;

  localparam int FP_ADD_LAT = 2;
endpackage

// File: rtl/fp_add.sv
// rtl/fp_add.sv - pipelined bfloat16 adder, round-to-nearest-even
// Purpose: sum = opA + opB after LAT register stages. Subnormal inputs and
//   results flush to zero; overflow saturates to signed infinity.
// Ports:
//   clk, reset                   : clock, asynchronous active-high reset
//   opA, opB                     : bf16 operands
//   sum                          : bf16 result, LAT cycles after operands
//   underflow, overflow, inexact : flags aligned with sum
module fp_add
  import fp_pkg::*;
#(
  parameter int LAT = FP_ADD_LAT
) (
  input  logic  clk,
  input  logic  reset,
  input  bf16_t opA,
  input  bf16_t opB,
  output bf16_t sum,
  output logic  underflow,
  output logic  overflow,
  output logic  inexact
);
  bf16_t       w_a, w_b, w_res;
  logic [7:0]  w_ea, w_eb, w_d;
  logic [17:0] w_mx, w_my, w_bext, w_n;
  logic [18:0] w_s;
  logic        w_sub, w_stk, w_g, w_rest, w_up;
  logic [8:0]  w_m9;
  logic [4:0]  w_lz;
  int          w_e;
  fp_flags_t   w_fl;

  bf16_t       r_sum [LAT];
  fp_flags_t   r_fl  [LAT];

  always_comb begin
    // Order by magnitude so the exponent difference is non-negative.
    if (opB[14:0] > opA[14:0]) begin
      w_a = opB;
      w_b = opA;
    end else begin
      w_a = opA;
      w_b = opB;
    end
    w_ea   = w_a[14:7];
    w_eb   = w_b[14:7];
    w_d    = w_ea - w_eb;
    w_sub  = w_a[15] ^ w_b[15];
    // 8-bit significand followed by 10 guard bits.
    w_mx   = (w_ea == 8'd0) ? '0 : {1'b1, w_a[6:0], 10'd0};
    w_bext = (w_eb == 8'd0) ? '0 : {1'b1, w_b[6:0], 10'd0};
    if (w_d > 8'd17) begin
      w_my  = '0;
      w_stk = |w_bext;
    end else begin
      w_my  = w_bext >> w_d;
      w_stk = |(w_bext & ~(18'h3FFFF << w_d));
    end
    // Bits shifted out are folded into the lowest bit as a sticky.
    w_my[0] = w_my[0] | w_stk;
    w_s = w_sub ? ({1'b0, w_mx} - {1'b0, w_my}) : ({1'b0, w_mx} + {1'b0, w_my});

    w_lz = '0;
    for (int k = 0; k < 18; k++) begin
      if (w_s[k]) w_lz = 5'(17 - k);
    end
    if (w_s[18]) begin
      w_n = w_s[18:1] | {17'd0, w_s[0]};
      w_e = int'(w_ea) + 1;
    end else begin
      w_n = w_s[17:0] << w_lz;
      w_e = int'(w_ea) - int'(w_lz);
    end

    w_g    = w_n[9];
    w_rest = |w_n[8:0];
    w_up   = w_g & (w_rest | w_n[10]);
    w_m9   = {1'b0, w_n[17:10]} + {8'd0, w_up};
    if (w_m9[8]) w_e = w_e + 1;

    w_fl         = '0;
    w_fl.inexact = w_g | w_rest;
    w_res = {w_a[15], 8'(w_e), (w_m9[8] ? w_m9[7:1] : w_m9[6:0])};

    if (w_ea == 8'hFF) begin
      // Inf/NaN operand: inf - inf gives the canonical quiet NaN.
      w_res = (w_eb == 8'hFF && w_sub) ? 16'h7FC0 : w_a;
      w_fl  = '0;
    end else if (w_s == '0) begin
      w_res = '0;
      w_fl  = '0;
    end else if (w_e >= 255) begin
      w_res         = {w_a[15], 8'hFF, 7'd0};
      w_fl.overflow = 1'b1;
      w_fl.inexact  = 1'b1;
    end else if (w_e <= 0) begin
      w_res          = {w_a[15], 15'd0};
      w_fl.underflow = 1'b1;
      w_fl.inexact   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < LAT; k++) begin
        r_sum[k] <= '0;
        r_fl[k]  <= '0;
      end
    end else begin
      r_sum[0] <= w_res;
      r_fl[0]  <= w_fl;
      for (int k = 1; k < LAT; k++) begin
        r_sum[k] <= r_sum[k-1];
        r_fl[k]  <= r_fl[k-1];
      end
    end
  end

  assign sum = r_sum[LAT-1];
  assign {underflow, overflow, inexact} = r_fl[LAT-1];
endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with advance-on-grant pointer
// Purpose: one-hot grant to the first requester at or after the pointer.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   req        : [N] request vector
//   advance    : move pointer past the current winner at the next edge
//   grant      : [N] one-hot (or zero) combinational grant
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_j;
  logic          w_found;

  // Walk ptr, ptr+1, ... (mod N); the first asserted request wins.
  always_comb begin
    grant   = '0;
    w_idx   = '0;
    w_j     = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_j = PW'((int'(r_ptr) + k) % N);
      if (!w_found && req[w_j]) begin
        w_found  = 1'b1;
        w_idx    = w_j;
        grant[w_j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= (w_idx == PW'(N - 1)) ? '0 : w_idx + 1'b1;
    end
  end
endmodule

// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin sharing of one pipelined bf16 adder
// Purpose: grant one requester per cycle, tag the issue, steer the result
//   back into that requester's response slot ADD_LAT+1 cycles later.
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   req_valid/req_ready         : [N_REQ] request handshake (ready is comb.)
//   req_opA/req_opB/req_sub     : operands, req_sub=1 computes A-B
//   rsp_valid/rsp_ready         : [N_REQ] response handshake
//   rsp_sum/rsp_flags           : held result and {underflow,overflow,inexact}
//   busy                        : any requester has an operation pending
module fp_add_arbiter
  import fp_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADD_LAT = FP_ADD_LAT,
  parameter int TAG_W   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0][15:0] req_opA,
  input  logic [N_REQ-1:0][15:0] req_opB,
  input  logic [N_REQ-1:0]       req_sub,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [N_REQ-1:0][15:0] rsp_sum,
  output logic [N_REQ-1:0][2:0]  rsp_flags,
  output logic                   busy
);
  logic [N_REQ-1:0]       w_elig, w_grant, w_rsp_hs, w_pend_nxt;
  logic [N_REQ-1:0]       r_pend, r_rsp_valid;
  logic [N_REQ-1:0][15:0] r_rsp_sum;
  logic [N_REQ-1:0][2:0]  r_rsp_flags;
  logic                   r_busy, w_any;
  logic [TAG_W-1:0]       w_gidx;
  bf16_t                  w_opA, w_opB, w_sum;
  logic                   w_unf, w_ovf, w_inx;
  logic [ADD_LAT-1:0]     r_tag_v;
  logic [TAG_W-1:0]       r_tag [ADD_LAT];

  // A slot being emptied this cycle may immediately take a new request.
  assign w_elig = req_valid & (~r_pend | (r_rsp_valid & rsp_ready));

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (w_elig),
    .advance (w_any),
    .grant   (w_grant)
  );

  assign req_ready  = w_grant & {N_REQ{~reset}};
  assign w_any      = |req_ready;
  assign w_rsp_hs   = r_rsp_valid & rsp_ready;
  // Re-issue in the response cycle keeps pend set.
  assign w_pend_nxt = req_ready | (r_pend & ~w_rsp_hs);

  always_comb begin
    w_opA  = '0;
    w_opB  = '0;
    w_gidx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        w_opA  = req_opA[i];
        w_opB  = req_opB[i] ^ {req_sub[i], 15'd0};
        w_gidx = TAG_W'(i);
      end
    end
  end

  fp_add #(.LAT(ADD_LAT)) u_add (
    .clk       (clk),
    .reset     (reset),
    .opA       (w_opA),
    .opB       (w_opB),
    .sum       (w_sum),
    .underflow (w_unf),
    .overflow  (w_ovf),
    .inexact   (w_inx)
  );

  // Tag pipe runs in lockstep with the adder stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag_v <= '0;
      for (int k = 0; k < ADD_LAT; k++) r_tag[k] <= '0;
    end else begin
      r_tag_v[0] <= w_any;
      r_tag[0]   <= w_gidx;
      for (int k = 1; k < ADD_LAT; k++) begin
        r_tag_v[k] <= r_tag_v[k-1];
        r_tag[k]   <= r_tag[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend      <= '0;
      r_busy      <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_sum   <= '0;
      r_rsp_flags <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_busy <= |w_pend_nxt;
      for (int i = 0; i < N_REQ; i++) begin
        // pend guarantees the target slot is empty at writeback.
        if (r_tag_v[ADD_LAT-1] && r_tag[ADD_LAT-1] == TAG_W'(i)) begin
          r_rsp_valid[i] <= 1'b1;
          r_rsp_sum[i]   <= w_sum;
          r_rsp_flags[i] <= {w_unf, w_ovf, w_inx};
        end else if (rsp_ready[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_flags = r_rsp_flags;
  assign busy      = r_busy;
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - directed scoreboard bench for fp_add_arbiter
module tb_fp_add_arbiter;
  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        req_valid, req_ready, req_sub, rsp_valid, rsp_ready;
  logic [3:0][15:0]  req_opA, req_opB, rsp_sum;
  logic [3:0][2:0]   rsp_flags;
  logic              busy;

  typedef struct packed {
    logic [1:0]  id;
    logic [18:0] e_val;
    logic [18:0] e_mask;
  } sb_t;

  sb_t         sb [$];
  logic [18:0] drv_exp  [4];
  logic [18:0] drv_mask [4];
  int          grant_log [$];
  int          rsp_log   [$];
  int          rsp_cyc   [$];
  int          rsp_cnt   [4];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          mk;
  int          lat, bad, seen, snap;
  logic [3:0]  w;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fp_add_arbiter #(.N_REQ(4), .ADD_LAT(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_opA   (req_opA),
    .req_opB   (req_opB),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_flags (rsp_flags),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: push on request handshake, pop oldest entry of that id on response.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          mk = -1;
          for (int j = 0; j < sb.size(); j++) if (mk < 0 && sb[j].id == 2'(i)) mk = j;
          rsp_log.push_back(i);
          rsp_cyc.push_back(cyc);
          rsp_cnt[i]++;
          if (mk < 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL rsp_unexpected requester=%0d observed=%0h expected=none", i, rsp_sum[i]);
          end else begin
            check($sformatf("rsp%0d_data", i), 32'({rsp_flags[i], rsp_sum[i]} & sb[mk].e_mask),
                  32'(sb[mk].e_val & sb[mk].e_mask));
            sb.delete(mk);
          end
        end
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{id: 2'(i), e_val: drv_exp[i], e_mask: drv_mask[i]});
          grant_log.push_back(i);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [18:0] e, input logic [18:0] m);
    req_opA[i]   = a;
    req_opB[i]   = b;
    req_sub[i]   = s;
    drv_exp[i]   = e;
    drv_mask[i]  = m;
    req_valid[i] = 1'b1;
  endtask

  // Called one cycle after the handshake; returns cycles from handshake to rsp_valid.
  task automatic wait_rsp(input int i, output int l);
    l = 1;
    while (!rsp_valid[i] && l < 20) begin
      tick();
      l++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_sub   = '0;
    req_opA   = '0;
    req_opB   = '0;
    rsp_ready = '1;
    for (int i = 0; i < 4; i++) begin
      drv_exp[i]  = '0;
      drv_mask[i] = '1;
      rsp_cnt[i]  = 0;
    end
    repeat (2) tick();
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_req_ready", 32'(req_ready), 32'h0);
    check("reset_rsp_sum", 32'(rsp_sum), 32'h0);
    reset = 1'b0;
    tick();

    // Single add on requester 0: 100 + 0.5
    set_req(0, 16'h42C8, 16'h3F00, 1'b0, {3'b000, 16'h42C9}, '1);
    #1 check("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid[0] = 1'b0;
    check("t1_busy", 32'(busy), 32'h1);
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("t1_rsp_valid_c%0d", k), 32'(rsp_valid[0]), 32'((k == 3) ? 1 : 0));
      if (k < 3) tick();
    end
    tick();
    check("t1_rsp_cleared", 32'(rsp_valid[0]), 32'h0);
    check("t1_idle", 32'(busy), 32'h0);

    // Subtract on requester 1: 100 - 0.5
    set_req(1, 16'h42C8, 16'h3F00, 1'b1, {3'b000, 16'h42C7}, '1);
    tick();
    req_valid[1] = 1'b0;
    wait_rsp(1, lat);
    check("t2_latency", 32'(lat), 32'd3);
    tick();

    // Requester 3 once more so the pointer wraps back to 0: 1 + 1
    set_req(3, 16'h3F80, 16'h3F80, 1'b0, {3'b000, 16'h4000}, '1);
    tick();
    req_valid[3] = 1'b0;
    wait_rsp(3, lat);
    check("t3_prep_latency", 32'(lat), 32'd3);
    tick();

    // All four at once
    grant_log.delete();
    rsp_log.delete();
    rsp_cyc.delete();
    set_req(0, 16'h3F80, 16'h4000, 1'b0, {3'b000, 16'h4040}, '1);
    set_req(1, 16'h4040, 16'h3F80, 1'b1, {3'b000, 16'h4000}, '1);
    set_req(2, 16'h4120, 16'h4120, 1'b0, {3'b000, 16'h41A0}, '1);
    set_req(3, 16'h3F80, 16'h3B80, 1'b0, {3'b001, 16'h3F80}, '1);
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("t3_grant%0d", k), 32'(req_ready), 32'(4'b0001 << k));
      tick();
      req_valid[k] = 1'b0;
      check($sformatf("t3_busy_c%0d", k + 1), 32'(busy), 32'h1);
    end
    for (int k = 4; k <= 8; k++) begin
      check($sformatf("t3_busy_c%0d", k), 32'(busy), 32'((k <= 6) ? 1 : 0));
      tick();
    end
    check("t3_rsp_count", 32'(rsp_log.size()), 32'd4);
    if (rsp_log.size() == 4) begin
      for (int j = 0; j < 4; j++) check($sformatf("t3_rsp_order%0d", j), 32'(rsp_log[j]), 32'(j));
      check("t3_rsp_consecutive", 32'(rsp_cyc[3] - rsp_cyc[0]), 32'd3);
    end

    // Fairness between requesters 0 and 2
    grant_log.delete();
    set_req(0, 16'h4000, 16'h4000, 1'b0, {3'b000, 16'h4080}, '1);
    set_req(2, 16'h4040, 16'h4040, 1'b0, {3'b000, 16'h40C0}, '1);
    repeat (20) tick();
    req_valid = '0;
    repeat (8) tick();
    bad = 0;
    for (int j = 1; j < grant_log.size(); j++) if (grant_log[j] == grant_log[j-1]) bad++;
    check("t4_repeat_grants", 32'(bad), 32'd0);
    check("t4_grant_count", 32'(grant_log.size()), 32'd14);
    if (grant_log.size() > 0) check("t4_first_grant", 32'(grant_log[0]), 32'd0);

    // Backpressure on requester 1
    rsp_ready[1] = 1'b0;
    set_req(1, 16'h4000, 16'h4000, 1'b0, {3'b000, 16'h4080}, '1);
    tick();
    req_valid[1] = 1'b0;
    wait_rsp(1, lat);
    check("t5_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 4; i++) rsp_cnt[i] = 0;
    set_req(1, 16'h3F80, 16'h3F80, 1'b0, {3'b000, 16'h4000}, '1);
    set_req(0, 16'h3F80, 16'h4000, 1'b0, {3'b000, 16'h4040}, '1);
    set_req(2, 16'h4040, 16'h3F80, 1'b1, {3'b000, 16'h4000}, '1);
    set_req(3, 16'h3F80, 16'h3B80, 1'b0, {3'b001, 16'h3F80}, '1);
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("t5_hold_valid%0d", k), 32'(rsp_valid[1]), 32'h1);
      check($sformatf("t5_hold_sum%0d", k), 32'(rsp_sum[1]), 32'h4080);
      check($sformatf("t5_blocked%0d", k), 32'(req_ready[1]), 32'h0);
      w = req_ready;
      tick();
      req_valid = req_valid & ~(w & 4'b1101);
    end
    check("t5_done0", 32'(rsp_cnt[0]), 32'd1);
    check("t5_done2", 32'(rsp_cnt[2]), 32'd1);
    check("t5_done3", 32'(rsp_cnt[3]), 32'd1);
    rsp_ready[1] = 1'b1;
    #1 check("t5_release_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid[1] = 1'b0;
    wait_rsp(1, lat);
    check("t5_reissue_latency", 32'(lat), 32'd3);
    tick();

    // Overflow: only the sum and the overflow flag are constrained
    set_req(2, 16'h7F7E, 16'h7E82, 1'b0, {3'b010, 16'h7F80}, {3'b010, 16'hFFFF});
    tick();
    req_valid[2] = 1'b0;
    wait_rsp(2, lat);
    check("t6_latency", 32'(lat), 32'd3);
    tick();

    // Reset one cycle after a grant
    set_req(0, 16'h3F80, 16'h3F80, 1'b0, {3'b000, 16'h4000}, '1);
    tick();
    req_valid[0] = 1'b0;
    set_req(3, 16'h3F80, 16'h3F80, 1'b0, {3'b000, 16'h4000}, '1);
    reset = 1'b1;
    #1;
    check("t7_rsp_valid", 32'(rsp_valid), 32'h0);
    check("t7_busy", 32'(busy), 32'h0);
    check("t7_req_ready", 32'(req_ready), 32'h0);
    check("t7_rsp_sum", 32'(rsp_sum), 32'h0);
    check("t7_rsp_flags", 32'(rsp_flags), 32'h0);
    req_valid = '0;
    repeat (2) tick();
    reset = 1'b0;
    snap = rsp_cnt[0];
    seen = 0;
    repeat (8) begin
      tick();
      if (rsp_valid != 4'b0) seen++;
    end
    check("t7_no_rsp_after_reset", 32'(seen), 32'd0);
    check("t7_rsp_count", 32'(rsp_cnt[0]), 32'(snap));
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

Round-robin scheduler that shares one pipelined `fp_add` (bfloat16, 1-8-7) among `N_REQ` requesters. Each requester has a valid/ready request channel and a valid/ready response channel, and may have at most one operation outstanding. The block tags every issued operation, tracks the tag through a shift register matched to the adder latency, and steers the sum and flags back to the owning requester's response slot. It sits between the FPU datapath and its clients (vector lanes, accumulators).

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `ADD_LAT`, 2: `fp_add` pipeline depth in cycles. Must equal the instantiated adder's depth.
- `TAG_W`, `$clog2(N_REQ)`: tag width (derived).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  [N_REQ]  request present.
- `req_ready`  out  [N_REQ]  request granted this cycle.
- `req_opA`  in  [N_REQ][16]  bf16 operand A.
- `req_opB`  in  [N_REQ][16]  bf16 operand B.
- `req_sub`  in  [N_REQ]  1 = compute A − B (sign of B inverted before issue).
- `rsp_valid`  out  [N_REQ]  result held in slot.
- `rsp_ready`  in  [N_REQ]  requester takes result.
- `rsp_sum`  out  [N_REQ][16]  bf16 result.
- `rsp_flags`  out  [N_REQ][3]  {underflow, overflow, inexact}.
- `busy`  out  1  OR of all pending bits.

## Operation
- `pend[i]` is set on request handshake and cleared on response handshake. It covers both the in-flight and the holding period.
- Eligibility: `eligible[i] = req_valid[i] && (!pend[i] || (rsp_valid[i] && rsp_ready[i]))`. A requester may re-issue in the same cycle its response is taken; in that case `pend[i]` stays 1.
- Arbitration:
  - Round-robin pointer `ptr`, reset value 0. Search order is `ptr, ptr+1, … , ptr+N_REQ−1` mod `N_REQ`.
  - The first eligible requester wins. At most one grant per cycle.
  - `req_ready` is combinational and one-hot or zero. It may depend on `req_valid`; requesters must not make `req_valid` depend on `req_ready`.
  - On a grant to `g`, `ptr <= (g+1) mod N_REQ` (wraps from `N_REQ−1` to 0). With no grant, `ptr` holds.
- Issue:
  - The granted operands drive `fp_add` `opA`/`opB` in the grant cycle. `opB[15]` is XORed with `req_sub`.
  - With no grant, both operands are driven to 0.
- Tag pipe: `ADD_LAT` stages of {valid, tag}. Stage 0 loads {grant, g}.
- Writeback:
  - When the last stage is valid with tag `t`, `rsp_sum[t]`/`rsp_flags[t]` capture the adder `sum` and flags, and `rsp_valid[t] <= 1`.
  - `rsp_valid[t]` clears on `rsp_ready[t]`.
  - Slot data is stable while `rsp_valid` is high.
  - Writeback never collides with an occupied slot, because of the `pend` rule.
- Reset values:
  - `ptr`, `pend`, tag-pipe valids, `rsp_valid`, `rsp_sum`, `rsp_flags`, `busy` = 0.
  - Reset mid-operation discards in-flight operations; no response is produced for them.

## Timing
- Handshake in cycle c → adder `sum` valid in cycle c+`ADD_LAT` → `rsp_valid` high from cycle c+`ADD_LAT`+1. Default latency is 3 cycles.
- Throughput is one issue per cycle across requesters.
- Per requester, with `rsp_ready` tied high, the minimum issue interval is `ADD_LAT`+1 cycles (re-issue in the response cycle).
- `req_ready` has no registered delay. Grant and `ptr` update take effect at the same edge.
- `busy` is registered (derived from `pend`).

## Structure
- `fp_pkg` holds:
  - `bf16_t` (logic [15:0]);
  - `fp_flags_t` packed struct {underflow, overflow, inexact};
  - `FP_ADD_LAT` = 2, used as the default for `ADD_LAT`.
- Sub-modules:
  - `fp_add` is instantiated as-is (`clk`, `reset`, `opA`, `opB`, `sum`, `underflow`, `overflow`, `inexact`).
  - `rr_arbiter` (parameter N; `req` in, `grant` one-hot out, internal pointer, `advance` input) is a natural standalone sub-module.

## Test plan
- **Single request, add.** Requester 0 sends 0x42C8 + 0x3F00 (100 + 0.5) with `rsp_ready`=1. Required: `req_ready[0]` the same cycle; `rsp_valid[0]` exactly 3 cycles later with `rsp_sum`=0x42C9 and flags=000.
- **Subtract.** Requester 1 sends 0x42C8 and 0x3F00 with `req_sub`=1. Required: `rsp_sum[1]`=0x42C7 (99.5), flags=000.
- **All four at once.** All requesters valid in the same cycle, `ptr`=0. Required: grants 0,1,2,3 on consecutive cycles; responses on consecutive cycles in the same order; `busy` high throughout, low the cycle after the last response.
- **Fairness.** Requesters 0 and 2 continuously valid, `rsp_ready`=1, re-issuing on their response. Required: grant sequence alternates 0,2,0,2; never two consecutive grants to the same requester while the other is eligible.
- **Backpressure.**
  - Hold `rsp_ready[1]`=0 for 10 cycles after the result arrives. Required: `rsp_sum[1]` stable; `req_ready[1]`=0 despite `req_valid[1]`; requesters 0, 2, 3 still complete.
  - Release `rsp_ready[1]` with a new request pending. Required: the new request is granted in the same cycle.
- **Overflow and reset.**
  - 0x7F7E + 0x7E82 → `rsp_sum`=0x7F80, `overflow`=1.
  - Assert `reset` one cycle after a grant. Required: all outputs 0 immediately (asynchronous); no `rsp_valid` after release.
